mac_frame_sequencer: RTL and testbench
======================================

// Module: mac_frame_sequencer
// PURPOSE
// - Parametrised successor of the fixed 4-step accumulate controller: walks mux_sel over
//   NUM_CH datapath inputs per frame, pulses data_load/clear_accum on the last channel.
// - Adds start/done handshake, programmable frame count (0 = free-running), abort, busy.
// - Sits between the host/control FSM and the mux -> MAC -> output-register datapath.
// PARAMETERS
// - NUM_CH   4  channels (mux inputs) per frame; legal range 2..256.
// - FRAME_W  8  width of frame_count and of the internal frame counter.
// - SEL_W       localparam = $clog2(NUM_CH); not overridable.
// PORTS
// - clk          in   1        single clock, all state updates on its rising edge
// - reset        in   1        asynchronous, active-high
// - start        in   1        begin a run; sampled only in IDLE
// - frame_count  in   FRAME_W  frames per run, captured on accepted start; 0 = free-running
// - abort        in   1        end a run early; sampled only in RUN
// - stall        in   1        hold sequencing (present only with MAC_SEQ_STALL_EN)
// - mux_sel      out  SEL_W    datapath mux select = current channel index
// - data_load    out  1        one-cycle load enable on last channel of each frame
// - clear_accum  out  1        accumulator clear, coincident with data_load
// - busy         out  1        high throughout RUN
// - done         out  1        one-cycle pulse after final frame of a counted run
// BEHAVIOUR
// - Reset (async, immediate): state=IDLE, ch=0, frm=0, frame_count_q=0; all outputs 0.
// - States IDLE -> RUN -> DONE -> IDLE. Outputs are Moore (decoded from registers only).
// - IDLE: start=1 -> RUN next edge, ch=0, frm=0, frame_count_q<=frame_count. Else stay.
// - RUN: mux_sel=ch, busy=1. ch increments each cycle, wraps NUM_CH-1 -> 0; ch never
//   takes values >= NUM_CH (non-power-of-2 NUM_CH included).
// - RUN, ch==NUM_CH-1: data_load=1 and clear_accum=1 for that cycle; frm increments.
// - Counted run (frame_count_q!=0): when ch==NUM_CH-1 and frm==frame_count_q-1 -> DONE.
// - Free-running (frame_count_q==0): never enters DONE; frm wraps modulo 2^FRAME_W.
// - abort=1 in RUN: next state IDLE, ch=0, frm=0, no done pulse; current-cycle outputs
//   still follow state (data_load still fires if ch==NUM_CH-1). abort beats the DONE exit.
// - DONE: done=1, busy=0, mux_sel=0, for exactly one cycle -> IDLE. start ignored here.
// - start while busy or in DONE ignored; frame_count changes after capture have no effect.
// - Latency: start seen at edge k -> mux_sel=0,busy=1 in cycle k+1; first data_load in
//   cycle k+NUM_CH; done in cycle k+NUM_CH*frame_count+1.
// - Outside RUN: mux_sel=0, data_load=0, clear_accum=0.
// CONFIGURATION
// - MAC_SEQ_STALL_EN defined: stall port exists. stall=1 in RUN freezes ch, frm, state
//   transitions; mux_sel holds; data_load=clear_accum=0 that cycle; busy stays 1.
//   abort overrides stall. stall ignored outside RUN.
// - MAC_SEQ_STALL_EN undefined: no stall port; sequencing never pauses.
// TESTING
// - NUM_CH=4, frame_count=2, start 1 cycle -> mux_sel 0,1,2,3,0,1,2,3; data_load and
//   clear_accum in cycles 4 and 8; busy cycles 1-8; done cycle 9 only; IDLE cycle 10.
// - NUM_CH=5, frame_count=3 -> mux_sel 0..4 repeated 3x, never 5..7; 3 data_load pulses.
// - frame_count=0: run 300 frames (frm wraps), abort at ch=1 -> IDLE next cycle, busy=0,
//   done never asserted, no further data_load.
// - start re-pulsed mid-run and in DONE -> ignored; run length and done timing unchanged.
// - reset asserted mid-frame at ch=2 (between edges) -> all outputs 0 immediately; after
//   release start works normally from ch=0.
// - MAC_SEQ_STALL_EN: stall 3 cycles at ch=3 (NUM_CH=4) -> mux_sel holds 3, data_load=0
//   while stalled, single data_load on first unstalled cycle; done delayed by 3 cycles.

Source files
------------

// File: rtl/mac_frame_sequencer_if.sv
// Handshake and datapath-control bundle between the host FSM and mac_frame_sequencer.
// The stall signal exists only when MAC_SEQ_STALL_EN is defined.
interface mac_frame_sequencer_if #(
  parameter int NUM_CH  = 4,
  parameter int FRAME_W = 8
);
  localparam int SEL_W = $clog2(NUM_CH);

  logic               start;
  logic [FRAME_W-1:0] frame_count;
  logic               abort;
`ifdef MAC_SEQ_STALL_EN
  logic               stall;
`endif
  logic [SEL_W-1:0]   mux_sel;
  logic               data_load;
  logic               clear_accum;
  logic               busy;
  logic               done;

  modport master (
    output start, frame_count, abort,
`ifdef MAC_SEQ_STALL_EN
    output stall,
`endif
    input  mux_sel, data_load, clear_accum, busy, done
  );

  modport slave (
    input  start, frame_count, abort,
`ifdef MAC_SEQ_STALL_EN
    input  stall,
`endif
    output mux_sel, data_load, clear_accum, busy, done
  );
endinterface

// File: rtl/mac_frame_sequencer.sv
// Frame sequencer: steps mux_sel over NUM_CH channels per frame and pulses load/clear on
// the last channel. Defining MAC_SEQ_STALL_EN adds a stall input that freezes sequencing.
//
//   state  | meaning
//   S_IDLE | waiting for start, outputs quiet
//   S_RUN  | stepping channels, busy high
//   S_DONE | one-cycle done pulse after the last frame of a counted run
module mac_frame_sequencer #(
  parameter int NUM_CH  = 4,
  parameter int FRAME_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  mac_frame_sequencer_if.slave  bus
);
  localparam int               SEL_W   = $clog2(NUM_CH);
  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_CH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   ch_q, ch_d;
  logic [FRAME_W-1:0] frm_q, frm_d;
  logic [FRAME_W-1:0] fc_q, fc_d;
  logic               busy_q, done_q, last_q;
  logic               stall_w;

`ifdef MAC_SEQ_STALL_EN
  assign stall_w = bus.stall;
`else
  assign stall_w = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    frm_d   = frm_q;
    fc_d    = fc_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_RUN;
          ch_d    = '0;
          frm_d   = '0;
          fc_d    = bus.frame_count;
        end
      end
      S_RUN: begin
        // abort wins over both stall and the counted-run exit
        if (bus.abort) begin
          state_d = S_IDLE;
          ch_d    = '0;
          frm_d   = '0;
        end else if (!stall_w) begin
          if (ch_q == LAST_CH) begin
            ch_d  = '0;
            frm_d = frm_q + 1'b1;
            if ((fc_q != '0) && (frm_q == fc_q - 1'b1)) begin
              state_d = S_DONE;
              frm_d   = '0;
            end
          end else begin
            ch_d = ch_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        ch_d    = '0;
        frm_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      ch_q    <= '0;
      frm_q   <= '0;
      fc_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      frm_q   <= frm_d;
      fc_q    <= fc_d;
      busy_q  <= (state_d == S_RUN);
      done_q  <= (state_d == S_DONE);
      last_q  <= (state_d == S_RUN) && (ch_d == LAST_CH);
    end
  end

  // ch_q is held at zero outside RUN, so it doubles as the mux select directly
  assign bus.mux_sel     = ch_q;
  assign bus.data_load   = last_q & ~stall_w;
  assign bus.clear_accum = last_q & ~stall_w;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
endmodule

// File: tb/tb_mac_frame_sequencer.sv
// Bench for mac_frame_sequencer: NUM_CH=4 and NUM_CH=5 instances share stimulus and are
// checked every cycle against a run-position reference model.
module tb_mac_frame_sequencer;
  localparam int FW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          start_r;
  logic [FW-1:0] fc_r;
  logic          abort_r;
  logic          stall_r;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  int m_state [2];
  int m_pos   [2];
  int m_fc    [2];
  int done_cyc[2];
  int done_cnt[2];
  int ld_cnt  [2];
  int max_sel [2];

  always #5 clk = ~clk;

  mac_frame_sequencer_if #(.NUM_CH(4), .FRAME_W(FW)) if0 ();
  mac_frame_sequencer_if #(.NUM_CH(5), .FRAME_W(FW)) if1 ();

  assign if0.start       = start_r;
  assign if0.frame_count = fc_r;
  assign if0.abort       = abort_r;
  assign if1.start       = start_r;
  assign if1.frame_count = fc_r;
  assign if1.abort       = abort_r;
`ifdef MAC_SEQ_STALL_EN
  assign if0.stall       = stall_r;
  assign if1.stall       = stall_r;
`endif

  mac_frame_sequencer #(.NUM_CH(4), .FRAME_W(FW)) dut0 (.clk(clk), .reset(reset), .bus(if0.slave));
  mac_frame_sequencer #(.NUM_CH(5), .FRAME_W(FW)) dut1 (.clk(clk), .reset(reset), .bus(if1.slave));

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int nch(input int k);
    return (k == 0) ? 4 : 5;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_state[k] = 0;
      m_pos[k]   = 0;
      m_fc[k]    = 0;
    end
  endtask

  task automatic clear_stats();
    for (int k = 0; k < 2; k++) begin
      done_cyc[k] = -1;
      done_cnt[k] = 0;
      ld_cnt[k]   = 0;
      max_sel[k]  = 0;
    end
  endtask

  // model: 0=idle, 1=running at position m_pos (unstalled cycles since start), 2=done
  task automatic model_update();
    int n;
    for (int k = 0; k < 2; k++) begin
      n = nch(k);
      case (m_state[k])
        0: if (start_r) begin
             m_state[k] = 1;
             m_pos[k]   = 0;
             m_fc[k]    = int'(fc_r);
           end
        1: if (abort_r) m_state[k] = 0;
           else if (!stall_r) begin
             if (m_fc[k] != 0 && m_pos[k] + 1 == n * m_fc[k]) m_state[k] = 2;
             m_pos[k]++;
           end
        default: m_state[k] = 0;
      endcase
    end
  endtask

  task automatic check_one(input int k, input int sel, input int ld, input int cl,
                           input int bz, input int dn);
    int n, e_sel, e_ld, e_bz, e_dn;
    n = nch(k); e_sel = 0; e_ld = 0; e_bz = 0; e_dn = 0;
    if (m_state[k] == 1) begin
      e_bz  = 1;
      e_sel = m_pos[k] % n;
      e_ld  = (e_sel == n - 1 && !stall_r) ? 1 : 0;
    end else if (m_state[k] == 2) begin
      e_dn = 1;
    end
    chk($sformatf("mux_sel[%0d]", k), sel, e_sel);
    chk($sformatf("data_load[%0d]", k), ld, e_ld);
    chk($sformatf("clear_accum[%0d]", k), cl, e_ld);
    chk($sformatf("busy[%0d]", k), bz, e_bz);
    chk($sformatf("done[%0d]", k), dn, e_dn);
    if (dn != 0) begin done_cnt[k]++; done_cyc[k] = cyc; end
    if (ld != 0) ld_cnt[k]++;
    if (sel > max_sel[k]) max_sel[k] = sel;
  endtask

  task automatic check_outputs();
    check_one(0, int'(if0.mux_sel), int'(if0.data_load), int'(if0.clear_accum),
              int'(if0.busy), int'(if0.done));
    check_one(1, int'(if1.mux_sel), int'(if1.data_load), int'(if1.clear_accum),
              int'(if1.busy), int'(if1.done));
  endtask

  // entered at a falling edge with inputs already driven
  task automatic step();
    #1;
    check_outputs();
    @(posedge clk);
    if (reset) model_reset();
    else model_update();
    @(negedge clk);
    cyc++;
  endtask

  task automatic wait_sel0(input int want, input string tag);
    int guard;
    guard = 0;
    while (int'(if0.mux_sel) != want && guard < 12) begin
      step();
      guard++;
    end
    chk(tag, int'(if0.mux_sel), want);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    reset = 1'b1; start_r = 1'b0; abort_r = 1'b0; stall_r = 1'b0; fc_r = '0;
    model_reset();
    clear_stats();
    @(negedge clk);
    step();
    reset = 1'b0;
    step();

    // counted run of 2 frames, plain start pulse
    clear_stats();
    start_r = 1'b1; fc_r = 8'd2; t0 = cyc;
    step();
    start_r = 1'b0;
    repeat (12) step();
    chk("t1_done_lat0", done_cyc[0] - t0, 9);
    chk("t1_done_lat1", done_cyc[1] - t0, 11);
    chk("t1_loads0", ld_cnt[0], 2);
    chk("t1_loads1", ld_cnt[1], 2);
    chk("t1_dones0", done_cnt[0], 1);

    // 3 frames, start re-pulsed mid-run (with new count) and while dut0 is in DONE
    clear_stats();
    fc_r = 8'd3; t0 = cyc;
    for (int i = 0; i <= 20; i++) begin
      start_r = (i == 0 || i == 5 || i == 13);
      if (i == 5) fc_r = 8'd1;
      step();
    end
    start_r = 1'b0;
    chk("t2_done_lat0", done_cyc[0] - t0, 13);
    chk("t2_done_lat1", done_cyc[1] - t0, 16);
    chk("t2_loads0", ld_cnt[0], 3);
    chk("t2_loads1", ld_cnt[1], 3);
    chk("t2_maxsel1", max_sel[1], 4);
    chk("t2_dones1", done_cnt[1], 1);

    // free-running for 300 frames of dut0, then abort at channel 1
    clear_stats();
    start_r = 1'b1; fc_r = 8'd0;
    step();
    start_r = 1'b0;
    repeat (1200) step();
    wait_sel0(1, "t3_reach_ch1");
    abort_r = 1'b1;
    step();
    abort_r = 1'b0;
    repeat (6) step();
    chk("t3_dones0", done_cnt[0], 0);
    chk("t3_dones1", done_cnt[1], 0);
    chk("t3_loads0", ld_cnt[0], 300);
    chk("t3_loads1", ld_cnt[1], 240);
    chk("t3_busy0_after", int'(if0.busy), 0);

    // asynchronous reset mid-frame at channel 2
    clear_stats();
    start_r = 1'b1; fc_r = 8'd5;
    step();
    start_r = 1'b0;
    wait_sel0(2, "t4_reach_ch2");
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    chk("t4_rst_sel0", int'(if0.mux_sel), 0);
    chk("t4_rst_busy0", int'(if0.busy), 0);
    chk("t4_rst_load0", int'(if0.data_load), 0);
    chk("t4_rst_sel1", int'(if1.mux_sel), 0);
    chk("t4_rst_busy1", int'(if1.busy), 0);
    @(negedge clk);
    step();
    reset = 1'b0;
    step();
    clear_stats();
    start_r = 1'b1; fc_r = 8'd1; t0 = cyc;
    step();
    start_r = 1'b0;
    repeat (8) step();
    chk("t4_done_lat0", done_cyc[0] - t0, 5);
    chk("t4_done_lat1", done_cyc[1] - t0, 6);

`ifdef MAC_SEQ_STALL_EN
    // stall 3 cycles while dut0 sits on channel 3
    clear_stats();
    start_r = 1'b1; fc_r = 8'd2; t0 = cyc;
    step();
    start_r = 1'b0;
    wait_sel0(3, "t5_reach_ch3");
    stall_r = 1'b1;
    repeat (3) step();
    stall_r = 1'b0;
    repeat (12) step();
    chk("t5_done_lat0", done_cyc[0] - t0, 12);
    chk("t5_done_lat1", done_cyc[1] - t0, 14);
    chk("t5_loads0", ld_cnt[0], 2);
`endif

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      start_r = ($urandom % 4) == 0;
      fc_r    = FW'($urandom_range(0, 4));
      abort_r = ($urandom % 30) == 0;
`ifdef MAC_SEQ_STALL_EN
      stall_r = ($urandom % 5) == 0;
`endif
      step();
    end
    start_r = 1'b0; abort_r = 1'b1; stall_r = 1'b0;
    step();
    abort_r = 1'b0;
    repeat (4) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
